// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: column-multiplexed row sampling,
// per-frame hit accumulation and a frame-level press/release debounce FSM.
module keypad_scanner #(
   parameter int SCAN_DIVIDER   = 200_000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] io_row,
   output logic [3:0] io_col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int DW = (SCAN_DIVIDER > 1) ? $clog2(SCAN_DIVIDER) : 1;
   localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [DW-1:0] DIV_LAST  = DW'(SCAN_DIVIDER - 1);
   localparam logic [DW-1:0] DIV_ONE   = DW'(1);
   localparam logic [CW-1:0] DB_TARGET = CW'(DEBOUNCE_SCANS);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PRESS_DB = 2'd1,
      ST_HELD     = 2'd2,
      ST_REL_DB   = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      FR_EMPTY  = 2'd0,
      FR_SINGLE = 2'd1,
      FR_MULTI  = 2'd2
   } frame_t;

   function automatic logic [2:0] f_popcount4(input logic [3:0] v);
      return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
   endfunction

   // Only meaningful when exactly one bit is set; lowest set bit wins otherwise.
   function automatic logic [1:0] f_row_index(input logic [3:0] v);
      logic [1:0] idx;
      if (v[0])      idx = 2'd0;
      else if (v[1]) idx = 2'd1;
      else if (v[2]) idx = 2'd2;
      else           idx = 2'd3;
      return idx;
   endfunction

   logic [3:0]    r_row_meta;
   logic [3:0]    r_row_sync;
   logic [DW-1:0] r_div;
   logic [1:0]    r_col;
   logic [3:0]    r_io_col;
   logic [1:0]    r_hits;
   logic [3:0]    r_hit_code;
   state_t        r_state;
   logic [3:0]    r_cand;
   logic [CW-1:0] r_cnt;
   logic [3:0]    r_key_code;
   logic          r_key_valid;
   logic          r_key_held;

   logic          w_tick;
   logic          w_frame_end;
   logic [1:0]    w_col_next;
   logic [3:0]    w_row_act;
   logic [2:0]    w_col_hits;
   logic [2:0]    w_total;
   logic [1:0]    w_hits_sat;
   logic [3:0]    w_code_next;
   frame_t        w_frame_res;
   logic [CW-1:0] w_cnt_inc;

   // Two-flop synchronizer for the asynchronous row inputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_row_meta <= 4'b1111;
         r_row_sync <= 4'b1111;
      end else begin
         r_row_meta <= io_row;
         r_row_sync <= r_row_meta;
      end
   end

   // Scan timing and the combined per-frame classification of sampled rows.
   always_comb begin
      w_tick      = (r_div == DIV_LAST);
      w_frame_end = w_tick && (r_col == 2'd3);
      w_col_next  = r_col + 2'd1;
      w_row_act   = ~r_row_sync;
      w_col_hits  = f_popcount4(w_row_act);
      w_total     = {1'b0, r_hits} + w_col_hits;
      if (w_total >= 3'd2) begin
         w_hits_sat = 2'd2;
      end else begin
         w_hits_sat = w_total[1:0];
      end
      if (w_col_hits == 3'd1) begin
         w_code_next = {r_col, f_row_index(w_row_act)};
      end else begin
         w_code_next = r_hit_code;
      end
      if (w_total == 3'd0) begin
         w_frame_res = FR_EMPTY;
      end else if (w_total == 3'd1) begin
         w_frame_res = FR_SINGLE;
      end else begin
         w_frame_res = FR_MULTI;
      end
      if (r_cnt >= DB_TARGET) begin
         w_cnt_inc = DB_TARGET;
      end else begin
         w_cnt_inc = r_cnt + CNT_ONE;
      end
   end

   // Refresh divider, column index and the registered column drive.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div    <= '0;
         r_col    <= 2'd0;
         r_io_col <= 4'b1110;
      end else if (w_tick) begin
         r_div    <= '0;
         r_col    <= w_col_next;
         r_io_col <= ~(4'b0001 << w_col_next);
      end else begin
         r_div    <= r_div + DIV_ONE;
      end
   end

   // Frame accumulator; the frame-end tick consumes it and starts a fresh frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hits     <= 2'd0;
         r_hit_code <= 4'd0;
      end else if (w_frame_end) begin
         r_hits     <= 2'd0;
         r_hit_code <= 4'd0;
      end else if (w_tick) begin
         r_hits     <= w_hits_sat;
         r_hit_code <= w_code_next;
      end else begin
         r_hits     <= r_hits;
         r_hit_code <= r_hit_code;
      end
   end

   // Debounce FSM, stepped once per frame, with registered key outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_cand      <= 4'd0;
         r_cnt       <= '0;
         r_key_code  <= 4'd0;
         r_key_valid <= 1'b0;
         r_key_held  <= 1'b0;
      end else begin
         r_key_valid <= 1'b0;
         if (w_frame_end) begin
            case (r_state)
               ST_IDLE: begin
                  if (w_frame_res == FR_SINGLE) begin
                     r_cand <= w_code_next;
                     if (CNT_ONE >= DB_TARGET) begin
                        r_state     <= ST_HELD;
                        r_cnt       <= '0;
                        r_key_code  <= w_code_next;
                        r_key_valid <= 1'b1;
                        r_key_held  <= 1'b1;
                     end else begin
                        r_state <= ST_PRESS_DB;
                        r_cnt   <= CNT_ONE;
                     end
                  end else begin
                     r_state <= ST_IDLE;
                     r_cnt   <= '0;
                  end
               end
               ST_PRESS_DB: begin
                  if ((w_frame_res == FR_SINGLE) && (w_code_next == r_cand)) begin
                     if (w_cnt_inc >= DB_TARGET) begin
                        r_state     <= ST_HELD;
                        r_cnt       <= '0;
                        r_key_code  <= r_cand;
                        r_key_valid <= 1'b1;
                        r_key_held  <= 1'b1;
                     end else begin
                        r_cnt <= w_cnt_inc;
                     end
                  end else if (w_frame_res == FR_SINGLE) begin
                     r_cand <= w_code_next;
                     r_cnt  <= CNT_ONE;
                  end else begin
                     r_state <= ST_IDLE;
                     r_cnt   <= '0;
                  end
               end
               ST_HELD: begin
                  if (w_frame_res == FR_EMPTY) begin
                     if (CNT_ONE >= DB_TARGET) begin
                        r_state    <= ST_IDLE;
                        r_cnt      <= '0;
                        r_key_held <= 1'b0;
                     end else begin
                        r_state <= ST_REL_DB;
                        r_cnt   <= CNT_ONE;
                     end
                  end else begin
                     r_cnt <= '0;
                  end
               end
               ST_REL_DB: begin
                  if (w_frame_res == FR_EMPTY) begin
                     if (w_cnt_inc >= DB_TARGET) begin
                        r_state    <= ST_IDLE;
                        r_cnt      <= '0;
                        r_key_held <= 1'b0;
                     end else begin
                        r_cnt <= w_cnt_inc;
                     end
                  end else begin
                     r_state <= ST_HELD;
                     r_cnt   <= '0;
                  end
               end
               default: begin
                  r_state    <= ST_IDLE;
                  r_cnt      <= '0;
                  r_key_held <= 1'b0;
               end
            endcase
         end else begin
            r_state <= r_state;
         end
      end
   end

   assign io_col    = r_io_col;
   assign key_code  = r_key_code;
   assign key_valid = r_key_valid;
   assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized self-checking bench for keypad_scanner with a frame-level
// behavioural model of press/release qualification.
module tb_keypad_scanner;

   localparam int SD = 4;
   localparam int DB = 2;
   localparam int FR = 4 * SD;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [3:0]  io_row;
   logic [3:0]  io_col;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_held;
   logic [15:0] keys = 16'h0000;

   int n_checks = 0;
   int n_errors = 0;

   // Model: frame results since the last state change, held flag, last code.
   int       hist[$];
   bit       m_held = 1'b0;
   int       m_code = 0;

   keypad_scanner #(.SCAN_DIVIDER(SD), .DEBOUNCE_SCANS(DB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .io_row    (io_row),
      .io_col    (io_col),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   always #5 clk = ~clk;

   // Physical matrix: a pressed key at (c,r) pulls row r low while column c is driven low.
   always_comb begin
      io_row = 4'hF;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            if (keys[c*4+r] && !io_col[c]) io_row[r] = 1'b0;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // -1 = no key, -2 = several keys, otherwise the key index col*4+row.
   function automatic int frame_result(input logic [15:0] m);
      if (m == 16'h0000) return -1;
      if ($countones(m) > 1) return -2;
      for (int i = 0; i < 16; i++) if (m[i]) return i;
      return -2;
   endfunction

   task automatic model_step(input int res, output bit pulse);
      bit same;
      int n;
      pulse = 1'b0;
      hist.push_back(res);
      n = hist.size();
      if (n >= DB) begin
         if (!m_held) begin
            same = (hist[n-1] >= 0);
            for (int k = 1; k < DB; k++) if (hist[n-1-k] != hist[n-1]) same = 1'b0;
            if (same) begin
               m_held = 1'b1;
               m_code = hist[n-1];
               pulse  = 1'b1;
               hist.delete();
            end
         end else begin
            same = 1'b1;
            for (int k = 0; k < DB; k++) if (hist[n-1-k] != -1) same = 1'b0;
            if (same) begin
               m_held = 1'b0;
               hist.delete();
            end
         end
      end
   endtask

   // Must be entered on a negedge just before the first edge of a frame.
   task automatic run_frame(input logic [15:0] m);
      bit         pulse;
      int         nv;
      logic [3:0] exp_col;
      logic [3:0] one;
      nv   = 0;
      one  = 4'b0001;
      keys = m;
      for (int i = 0; i < FR; i++) begin
         @(posedge clk);
         @(negedge clk);
         nv += int'(key_valid);
         exp_col = ~(one << (((i + 1) / SD) % 4));
         chk("io_col", 32'(io_col), 32'(exp_col));
      end
      model_step(frame_result(m), pulse);
      chk("key_valid", 32'(key_valid), 32'(pulse));
      chk("valid_pulses", 32'(nv), 32'(pulse));
      chk("key_held", 32'(key_held), 32'(m_held));
      chk("key_code", 32'(key_code), 32'(m_code));
   endtask

   task automatic run_cycles(input logic [15:0] m, input int n);
      keys = m;
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_io_col", 32'(io_col), 32'h0000_000E);
      chk("rst_valid", 32'(key_valid), 32'h0);
      chk("rst_held", 32'(key_held), 32'h0);
      chk("rst_code", 32'(key_code), 32'h0);
      repeat (3) @(negedge clk);
      hist.delete();
      m_held = 1'b0;
      m_code = 0;
      rst_n  = 1'b1;
   endtask

   initial begin
      logic [15:0] m;
      int          r;
      #1;
      do_reset();
      repeat (2) run_frame(16'h0000);

      // Clean press of column 2 / row 2, then release.
      repeat (4) run_frame(16'h0001 << 10);
      chk("clean_code", 32'(key_code), 32'h0000_000A);
      repeat (2) run_frame(16'h0000);

      // Bounce every frame, then steady.
      repeat (2) begin
         run_frame(16'h0001 << 10);
         run_frame(16'h0000);
      end
      repeat (2) run_frame(16'h0001 << 10);
      repeat (2) run_frame(16'h0000);

      // Ghost/multi: col1-row0 together with col3-row3.
      repeat (5) run_frame((16'h0001 << 4) | (16'h0001 << 15));
      repeat (2) run_frame(16'h0000);

      // Hold one key, roll to another, short release, real release.
      repeat (2) run_frame(16'h0001 << 5);
      repeat (3) run_frame(16'h0001 << 9);
      run_frame(16'h0000);
      repeat (2) run_frame(16'h0001 << 9);
      repeat (2) run_frame(16'h0000);
      chk("retained_code", 32'(key_code), 32'd5);

      // Reset while held; the same key must re-qualify.
      repeat (3) run_frame(16'h0001 << 6);
      run_cycles(16'h0001 << 6, 7);
      do_reset();
      repeat (2) run_frame(16'h0001 << 6);
      repeat (2) run_frame(16'h0000);

      // Reset during press debounce.
      run_frame(16'h0001 << 3);
      run_cycles(16'h0001 << 3, 5);
      do_reset();
      repeat (3) run_frame(16'h0001 << 3);
      repeat (2) run_frame(16'h0000);

      // Random keypad activity.
      m = 16'h0000;
      for (int f = 0; f < 150; f++) begin
         r = $urandom_range(0, 99);
         if (r < 40) begin
            m = m;
         end else if (r < 65) begin
            m = 16'h0000;
         end else if (r < 90) begin
            m = 16'h0001 << $urandom_range(0, 15);
         end else begin
            m = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
         end
         run_frame(m);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
      $fatal(1, "watchdog expired");
   end

endmodule
